// File: rtl/sram32_if.sv
// Bus-side request/acknowledge channel between a master and the sram32_ctrl controller.
interface sram32_if #(
    parameter int ADDR_W = 22
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/sram32_ctrl.sv
// Single-word read/write sequencer for a 32-bit asynchronous SRAM with programmable wait states.
// Optional SRAM32_STATS_EN adds completed-read/write counters rd_count and wr_count.
module sram32_ctrl #(
    parameter int ADDR_W     = 22,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic              refclk,
    input  logic              rst_n,
    sram32_if.slave           bus,
    output logic [ADDR_W-1:0] sram_adr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic [31:0]       sram_d_o,
    output logic              sram_d_oe,
    input  logic [31:0]       sram_d_i
`ifdef SRAM32_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int RdWait  = (READ_WAIT < 1) ? 1 : READ_WAIT;
    localparam int WrWait  = (WRITE_WAIT < 1) ? 1 : WRITE_WAIT;
    localparam int MaxWait = (RdWait > WrWait) ? RdWait : WrWait;
    localparam int CntW    = (MaxWait > 1) ? $clog2(MaxWait) : 1;
    localparam logic [CntW-1:0] RdLoad = CntW'(RdWait - 1);
    localparam logic [CntW-1:0] WrLoad = CntW'(WrWait - 1);

    typedef enum logic [2:0] {StIdle, StRd, StWrSetup, StWrPulse, StWrHold} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
            sram_adr  <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            sram_d_o  <= '0;
            sram_d_oe <= 1'b0;
`ifdef SRAM32_STATS_EN
            rd_count  <= '0;
            wr_count  <= '0;
`endif
        end else begin
            bus.ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Gating on ack keeps the request being dropped from being taken twice.
                    if (bus.req && !bus.ack) begin
                        sram_adr  <= bus.addr;
                        sram_ce_n <= 1'b0;
                        if (bus.we) begin
                            state     <= StWrSetup;
                            sram_we_n <= 1'b1;
                            sram_d_oe <= 1'b1;
                            sram_d_o  <= bus.wdata;
                            sram_be_n <= ~bus.be;
                        end else begin
                            state     <= StRd;
                            cnt       <= RdLoad;
                            sram_oe_n <= 1'b0;
                            sram_be_n <= 4'h0;
                        end
                    end
                end
                StRd: begin
                    if (cnt == '0) begin
                        state     <= StIdle;
                        bus.rdata <= sram_d_i;
                        bus.ack   <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_be_n <= 4'hF;
`ifdef SRAM32_STATS_EN
                        rd_count  <= rd_count + 32'd1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StWrSetup: begin
                    state     <= StWrPulse;
                    sram_we_n <= 1'b0;
                    cnt       <= WrLoad;
                end
                StWrPulse: begin
                    if (cnt == '0) begin
                        state     <= StWrHold;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StWrHold: begin
                    state     <= StIdle;
                    bus.ack   <= 1'b1;
                    sram_d_oe <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_be_n <= 4'hF;
`ifdef SRAM32_STATS_EN
                    wr_count  <= wr_count + 32'd1;
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram32_ctrl.sv
// Directed self-checking bench for sram32_ctrl with the sram32 behavioural read model attached.
module tb_sram32_ctrl;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic [21:0] sram_adr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_d_oe;
    logic [3:0]  sram_be_n;
    logic [31:0] sram_d_o, sram_d_i;
`ifdef SRAM32_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    int errors = 0;
    int checks = 0;

    // Monitor counters, sampled on the falling edge.
    int ack_cnt = 0, oe_low_cnt = 0, we_low_cnt = 0, doe_cnt = 0, overlap_cnt = 0, pin_bad = 0;
    logic [21:0] exp_adr  = '0;
    logic [3:0]  exp_be_n = 4'hF;
    logic [31:0] exp_d    = '0;

    sram32_if #(.ADDR_W(22)) bus ();

    sram32_ctrl #(.ADDR_W(22), .READ_WAIT(2), .WRITE_WAIT(2)) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sram_adr  (sram_adr),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_be_n (sram_be_n),
        .sram_d_o  (sram_d_o),
        .sram_d_oe (sram_d_oe),
        .sram_d_i  (sram_d_i)
`ifdef SRAM32_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    assign sram_d_i = sram_oe_n ? 32'h0 : ({10'b0, sram_adr} + 32'h0001_0000);

    always #5 refclk = ~refclk;

    always @(negedge refclk) begin
        if (bus.ack) ack_cnt++;
        if (!sram_oe_n) oe_low_cnt++;
        if (!sram_we_n) we_low_cnt++;
        if (sram_d_oe) doe_cnt++;
        if (sram_d_oe && !sram_oe_n) overlap_cnt++;
        if (sram_d_oe && (sram_adr !== exp_adr || sram_be_n !== exp_be_n || sram_d_o !== exp_d))
            pin_bad++;
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.ack && lat < 40);
        check(tag, {31'b0, bus.ack}, 32'h1);
    endtask

    task automatic do_read(input logic [21:0] a, output int lat);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        wait_ack("read_ack", lat);
        bus.req = 1'b0;
    endtask

    task automatic do_write(input logic [21:0] a, input logic [31:0] d, input logic [3:0] b,
                            output int lat);
        exp_adr  = a;
        exp_d    = d;
        exp_be_n = ~b;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        wait_ack("write_ack", lat);
        bus.req = 1'b0;
    endtask

    initial begin
        int lat;
        int base_ack, base_oe, base_we, base_doe;

        rst_n     = 1'b0;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 22'h5;
        bus.wdata = 32'h1234_5678;
        bus.be    = 4'hF;
        tick(); tick(); tick();
        check("rst_ack", {31'b0, bus.ack}, 32'h0);
        check("rst_ce_n", {31'b0, sram_ce_n}, 32'h1);
        check("rst_oe_n", {31'b0, sram_oe_n}, 32'h1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'h1);
        check("rst_be_n", {28'b0, sram_be_n}, 32'hF);
        check("rst_d_oe", {31'b0, sram_d_oe}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_adr", {10'b0, sram_adr}, 32'h0);

        bus.req = 1'b0;
        rst_n   = 1'b1;
        tick(); tick(); tick();
        check("idle_ce_n", {31'b0, sram_ce_n}, 32'h1);
        check("idle_no_ack", ack_cnt, 0);

        // Single read at 0x123.
        base_ack = ack_cnt;
        base_oe  = oe_low_cnt;
        do_read(22'h000123, lat);
        check("rd_latency", lat, 3);
        check("rd_data", bus.rdata, 32'h0001_0123);
        check("rd_ce_n_done", {31'b0, sram_ce_n}, 32'h1);
        tick();
        check("rd_ack_pulse", {31'b0, bus.ack}, 32'h0);
        check("rd_oe_cycles", oe_low_cnt - base_oe, 2);
        check("rd_ack_count", ack_cnt - base_ack, 1);
        tick();

        // Write at the top address; rdata must not move.
        base_ack = ack_cnt;
        base_we  = we_low_cnt;
        base_doe = doe_cnt;
        do_write(22'h3FFFFF, 32'hDEAD_BEEF, 4'b0101, lat);
        check("wr_latency", lat, 5);
        check("wr_rdata_kept", bus.rdata, 32'h0001_0123);
        tick();
        check("wr_we_cycles", we_low_cnt - base_we, 2);
        check("wr_doe_cycles", doe_cnt - base_doe, 4);
        check("wr_pins_stable", pin_bad, 0);
        check("wr_ack_count", ack_cnt - base_ack, 1);
        check("wr_d_oe_off", {31'b0, sram_d_oe}, 32'h0);
        tick();

        // Back-to-back with req held high throughout.
        base_ack = ack_cnt;
        exp_adr  = 22'h44;
        exp_d    = 32'hCAFE_F00D;
        exp_be_n = 4'h0;
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 22'h10;
        wait_ack("b2b_ack0", lat);
        check("b2b_rd0", bus.rdata, 32'h0001_0010);
        bus.we    = 1'b1;
        bus.addr  = 22'h44;
        bus.wdata = 32'hCAFE_F00D;
        bus.be    = 4'hF;
        wait_ack("b2b_ack1", lat);
        check("b2b_wr_lat", lat, 6);
        bus.we   = 1'b0;
        bus.addr = 22'h20;
        wait_ack("b2b_ack2", lat);
        bus.req = 1'b0;
        tick(); tick();
        check("b2b_ack_count", ack_cnt - base_ack, 3);
        check("b2b_overlap", overlap_cnt, 0);
        check("b2b_rdata", bus.rdata, 32'h0001_0020);
        check("b2b_pins_stable", pin_bad, 0);

        // Reset pulse while we_n is low.
        base_ack = ack_cnt;
        exp_adr  = 22'h77;
        exp_d    = 32'h0BAD_0BAD;
        exp_be_n = 4'h0;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 22'h77;
        bus.wdata = 32'h0BAD_0BAD;
        bus.be    = 4'hF;
        tick();
        tick();
        check("abort_we_low", {31'b0, sram_we_n}, 32'h0);
        rst_n   = 1'b0;
        bus.req = 1'b0;
        tick();
        check("abort_we_n", {31'b0, sram_we_n}, 32'h1);
        check("abort_d_oe", {31'b0, sram_d_oe}, 32'h0);
        check("abort_ce_n", {31'b0, sram_ce_n}, 32'h1);
        rst_n = 1'b1;
        tick(); tick();
        check("abort_no_ack", ack_cnt - base_ack, 0);
        do_read(22'h0002AB, lat);
        check("post_abort_lat", lat, 3);
        check("post_abort_data", bus.rdata, 32'h0001_02AB);
        tick();

        // All-ones address passes unchanged.
        do_read(22'h3FFFFF, lat);
        check("max_addr_adr", {10'b0, sram_adr}, 32'h003F_FFFF);
        check("max_addr_data", bus.rdata, 32'h0040_FFFF);
        tick();

        do_write(22'h000100, 32'h5555_AAAA, 4'b1100, lat);
        tick(); tick();
        check("final_overlap", overlap_cnt, 0);

`ifdef SRAM32_STATS_EN
        // Reads since the abort: 0x2AB, 0x3FFFFF (the earlier reset cleared the counters).
        check("stats_rd", rd_count, 32'd2);
        check("stats_wr", wr_count, 32'd1);
        for (int i = 0; i < 3; i++) begin
            do_read(22'h000200, lat);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            do_write(22'h000300, 32'h1, 4'hF, lat);
            tick();
        end
        check("stats_rd5", rd_count, 32'd5);
        check("stats_wr3", wr_count, 32'd3);
        force dut.rd_count = 32'hFFFF_FFFF;
        force dut.wr_count = 32'hFFFF_FFFF;
        tick();
        release dut.rd_count;
        release dut.wr_count;
        do_read(22'h000001, lat);
        tick();
        check("stats_rd_wrap", rd_count, 32'h0);
        check("stats_wr_held", wr_count, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram32_ctrl.md
Name: sram32_ctrl

Overview:
- Bus-side controller for the 32-bit asynchronous SRAM used on the board.
- Accepts single-word read/write requests over a req/ack handshake.
- Sequences the SRAM pins (address, chip enable, output enable, write enable, byte enables, data) with programmable wait states.
- Sits directly upstream of the SRAM device and of the sram32 sim bench model, which returns data = sram_adr + 0x0001_0000 while oe_n is low.

Parameters:
ADDR_W, 22, word-address width; drives sram_adr
READ_WAIT, 2, cycles oe_n is held low before data capture; values below 1 are treated as 1
WRITE_WAIT, 2, cycles we_n is held low per write; values below 1 are treated as 1

Ports:
refclk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active low
req  in  1  request; held by master until ack
we  in  1  1 = write, 0 = read; valid with req
addr  in  ADDR_W  word address; valid with req
wdata  in  32  write data; valid with req
be  in  4  byte enables, active high, write only
ack  out  1  one-cycle completion pulse
rdata  out  32  read data; valid with ack, held until next read capture
sram_adr  out  ADDR_W  SRAM address
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  4  byte lane enables, active low
sram_d_o  out  32  data to SRAM
sram_d_oe  out  1  1 = drive sram_d_o onto the pad
sram_d_i  in  32  data from SRAM pad

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; ack=0; rdata=0; sram_adr=0; sram_ce_n=1; sram_oe_n=1; sram_we_n=1; sram_be_n=4'hF; sram_d_o=0; sram_d_oe=0.
- Reset asserted mid-transaction aborts it: no ack, pins return to reset values at that edge.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: req is sampled only when ack=0. This prevents re-accepting the request the master is still dropping. On accept, latch we/addr/wdata/be.
- Read accepted at edge N:
  - RD for READ_WAIT cycles: ce_n=0, oe_n=0, be_n=0, d_oe=0, adr=latched addr.
  - At edge N+READ_WAIT: capture sram_d_i into rdata, ack=1, oe_n=1, ce_n=1, go to IDLE.
- Write accepted at edge N:
  - WR_SETUP, 1 cycle: ce_n=0, we_n=1, d_oe=1, d_o=wdata, be_n=~be.
  - WR_PULSE, WRITE_WAIT cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1; data, address and be_n held.
  - At edge N+WRITE_WAIT+2: ack=1, d_oe=0, ce_n=1, go to IDLE.
- A write never changes rdata.
- Wait counter: down-counter loaded with WAIT-1; state exits when the count is 0.
- sram_d_oe and sram_oe_n=0 are never simultaneously active. At least one cycle separates oe_n rising from d_oe rising.
- Back-to-back transactions: the earliest next accept is the edge after ack falls, giving a 1-cycle IDLE gap minimum.
- Address is not incremented; addr=all-ones is passed unchanged.
- Inputs that change while busy are ignored.

Optional Feature:
- Macro: SRAM32_STATS_EN.
- When defined: adds output ports rd_count[31:0] and wr_count[31:0].
  - Each increments by 1 in the same cycle its transaction's ack is asserted.
  - Each wraps from 0xFFFF_FFFF to 0.
  - Both clear on reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=1 -> ack=0, ce_n/oe_n/we_n=1, be_n=F, d_oe=0, no transaction after release until req is re-sampled in IDLE.
- Read with READ_WAIT=2, addr=0x000123, model attached -> oe_n low exactly 2 cycles, ack at edge N+2, rdata=0x0001_0123.
- Write with WRITE_WAIT=2, addr=0x3FFFFF, wdata=0xDEADBEEF, be=4'b0101:
  - Pins: we_n low exactly 2 cycles; d_oe high 4 cycles; be_n=4'b1010; adr=0x3FFFFF throughout; ack at edge N+4.
  - rdata keeps its prior value.
- Back-to-back read at 0x10 then write then read at 0x20 with req held high -> exactly 3 acks, d_oe never high while oe_n=0, final rdata=0x0001_0020.
- Reset pulse during WR_PULSE -> we_n=1 and d_oe=0 at that edge, no ack; a subsequent read completes normally.
- SRAM32_STATS_EN defined: 5 reads + 3 writes -> rd_count=5, wr_count=3. Force both counters to 0xFFFF_FFFF, then one read -> rd_count=0.
